// File: rtl/ssd1309_driver.sv
// ssd1309_driver: autonomous SSD1309 4-wire SPI driver that resets the panel,
// streams the init command list, then streams a checkerboard frame forever.
module ssd1309_driver #(
    parameter int STARTUP_DELAY = 2_700_000,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sclk,
    output logic sdin,
    output logic res,
    output logic cmd,
    output logic cs
);
    localparam int CW = $clog2(STARTUP_DELAY + 1);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [1:0] RST_LOW = 2'd0, RST_WAIT = 2'd1, INIT = 2'd2, FRAME = 2'd3;
    logic [1:0] r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [DW-1:0] r_div, w_div;
    logic [4:0] r_step, w_step;
    logic [9:0] r_idx, w_idx;
    logic [7:0] w_byte;
    logic w_in_byte;
    function automatic logic [7:0] init_rom(input logic [4:0] a);
        case (a)
            5'd0:  init_rom = 8'hAE;
            5'd1:  init_rom = 8'hD5;
            5'd2:  init_rom = 8'h80;
            5'd3:  init_rom = 8'hA8;
            5'd4:  init_rom = 8'h3F;
            5'd5:  init_rom = 8'hD3;
            5'd6:  init_rom = 8'h00;
            5'd7:  init_rom = 8'h40;
            5'd8:  init_rom = 8'hA1;
            5'd9:  init_rom = 8'hC8;
            5'd10: init_rom = 8'hDA;
            5'd11: init_rom = 8'h12;
            5'd12: init_rom = 8'h81;
            5'd13: init_rom = 8'h7F;
            5'd14: init_rom = 8'hD9;
            5'd15: init_rom = 8'h22;
            5'd16: init_rom = 8'hDB;
            5'd17: init_rom = 8'h34;
            5'd18: init_rom = 8'hA4;
            5'd19: init_rom = 8'hA6;
            5'd20: init_rom = 8'h20;
            5'd21: init_rom = 8'h00;
            5'd22: init_rom = 8'h21;
            5'd23: init_rom = 8'h00;
            5'd24: init_rom = 8'h7F;
            5'd25: init_rom = 8'h22;
            5'd26: init_rom = 8'h00;
            5'd27: init_rom = 8'h07;
            5'd28: init_rom = 8'hAF;
            default: init_rom = 8'h00;
        endcase
    endfunction
    // Byte = 16 half-bit steps (even low, odd high) plus step 16 as the cs-high gap.
    always_comb begin
        w_state = r_state;
        w_cnt = r_cnt;
        w_div = r_div;
        w_step = r_step;
        w_idx = r_idx;
        if (!r_state[1]) begin
            w_cnt = r_cnt + CW'(1);
            if (r_cnt == CW'(STARTUP_DELAY)) begin
                w_state = r_state == RST_LOW ? RST_WAIT : INIT;
                w_cnt = CW'(1);
                w_div = '0;
                w_step = '0;
                w_idx = '0;
            end
        end else if (r_div != DW'(CLK_DIV - 1)) begin
            w_div = r_div + DW'(1);
        end else begin
            w_div = '0;
            w_step = r_step == 5'd16 ? 5'd0 : r_step + 5'd1;
            if (r_step == 5'd16) begin
                w_idx = (r_state == INIT && r_idx == 10'd28) ? 10'd0 : r_idx + 10'd1;
                w_state = (r_state == INIT && r_idx == 10'd28) ? FRAME : r_state;
            end
        end
    end
    assign w_in_byte = w_state[1] && w_step != 5'd16;
    assign w_byte = w_state == FRAME ? {8{w_idx[3] ^ w_idx[7]}} : init_rom(w_idx[4:0]);
    // Pins are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RST_LOW;
            r_cnt <= '0;
            r_div <= '0;
            r_step <= '0;
            r_idx <= '0;
            sclk <= 1'b0;
            sdin <= 1'b0;
            res <= 1'b0;
            cmd <= 1'b0;
            cs <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt <= w_cnt;
            r_div <= w_div;
            r_step <= w_step;
            r_idx <= w_idx;
            sclk <= w_in_byte && w_step[0];
            sdin <= w_in_byte && w_byte[3'd7 - w_step[3:1]];
            res <= w_state != RST_LOW;
            cmd <= w_state == FRAME;
            cs <= !w_in_byte;
        end
    end
endmodule

// File: tb/tb_ssd1309_driver.sv
// tb_ssd1309_driver: decodes SPI bytes from the pins and compares them, with
// their start/end cycles, against an expected-byte queue; also checks SPI framing.
module tb_ssd1309_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk, sdin, res, cmd, cs;
    int n_chk = 0;
    int n_pass = 0;
    int cyc = -1;
    int viol = 0;
    int extra = 0;
    typedef struct {
        logic cmd;
        logic [7:0] data;
        int st;
    } ent_t;
    ent_t q[$];
    ent_t e;
    logic [7:0] init_list [29] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'h7F, 8'hD9, 8'h22, 8'hDB, 8'h34, 8'hA4, 8'hA6,
        8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};
    logic p_cs, p_sclk, p_sdin, p_cmd, bcmd;
    logic [7:0] sh;
    int st, edges;

    ssd1309_driver #(.STARTUP_DELAY(10), .CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .sdin(sdin), .res(res), .cmd(cmd), .cs(cs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= reset ? -1 : cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [7:0] fv(input int k);
        logic [9:0] kk;
        kk = k[9:0];
        return (kk[3] ^ kk[7]) ? 8'hFF : 8'h00;
    endfunction

    task automatic push_exp(input int nd);
        for (int i = 0; i < 29; i++) q.push_back('{1'b0, init_list[i], 20 + 34 * i});
        for (int k = 0; k < nd; k++) q.push_back('{1'b1, fv(k), 1006 + 34 * k});
    endtask

    task automatic startup();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("startup", {cs, sclk, res}, {1'b1, 1'b0, c >= 10});
        end
        @(posedge clk);
        @(negedge clk);
        chk("cs_fall", {cs, sdin, cmd}, 3'b010);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && q.size() != 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset || !res) begin
            p_cs = 1'b1;
            p_sclk = 1'b0;
            p_sdin = 1'b0;
            p_cmd = 1'b0;
            edges = 0;
        end else begin
            if (sclk && (sdin !== p_sdin || cmd !== p_cmd || cs !== p_cs)) viol++;
            if (!cs && p_cs) begin
                st = cyc;
                edges = 0;
                sh = 8'h00;
                bcmd = cmd;
            end
            if (sclk && !p_sclk) begin
                if (cs || cmd !== bcmd) viol++;
                edges++;
                sh = {sh[6:0], sdin};
            end
            if (cs && !p_cs) begin
                if (q.size() == 0) extra++;
                else begin
                    e = q.pop_front();
                    chk("cmd", bcmd, e.cmd);
                    chk("data", sh, e.data);
                    chk("start", st, e.st);
                    chk("rise", cyc, e.st + 32);
                    chk("edges", edges, 8);
                end
            end
            p_cs = cs;
            p_sclk = sclk;
            p_sdin = sdin;
            p_cmd = cmd;
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        push_exp(1025);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        startup();
        drain(40000);
        @(posedge clk);
        #2;
        for (int i = 0; i < 200 && !(sclk && cmd); i++) begin
            @(posedge clk);
            #2;
        end
        chk("mid_hi", {sclk, cmd}, 2'b11);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_rst", {sclk, cs, res, cmd}, 4'b0100);
        q.delete();
        push_exp(4);
        reset = 1'b0;
        startup();
        drain(3000);
        chk("proto", viol, 0);
        chk("extra", extra, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
